// File: rtl/instr_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : instr_dump_tx
// Description : Reads instruction words from a synchronous memory and sends
//               each one as two 8N1 UART frames, high byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_dump_tx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_max_addr,
    output logic        o_rd_en,
    output logic [7:0]  o_rd_addr,
    input  logic [15:0] i_rd_data,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam int c_CLK_DIV = CLK_FREQ / BAUD_RATE;
    localparam int c_BAUD_W  = $clog2(c_CLK_DIV);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_n;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_n;
    logic [15:0]         r_hold;
    logic                r_hi;
    logic [7:0]          r_addr;
    logic [7:0]          r_max;
    logic                r_tx;
    logic                w_tx_n;
    logic                w_tick;
    logic [7:0]          w_byte;

    assign w_tick = (r_baud == c_BAUD_LAST);
    assign w_byte = r_hi ? r_hold[15:8] : r_hold[7:0];

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_n = S_FETCH;
            S_FETCH: w_state_n = S_LATCH;
            S_LATCH: w_state_n = S_START;
            S_START: if (w_tick) w_state_n = S_DATA;
            S_DATA:  if (w_tick && r_bit == 3'd7) w_state_n = S_STOP;
            S_STOP: begin
                // Address is compared before any increment, so 255 never wraps.
                if (w_tick) begin
                    if (r_hi)                 w_state_n = S_START;
                    else if (r_addr == r_max) w_state_n = S_DONE;
                    else                      w_state_n = S_FETCH;
                end
            end
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_bit_n = r_bit;
        if (r_state == S_START)
            w_bit_n = 3'd0;
        else if (r_state == S_DATA && w_tick)
            w_bit_n = r_bit + 3'd1;

        w_baud_n = '0;
        if ((r_state == S_START || r_state == S_DATA || r_state == S_STOP) &&
            (w_state_n == r_state) && !w_tick)
            w_baud_n = r_baud + 1'b1;

        // Line level is computed for the upcoming state so o_tx is a register.
        w_tx_n = 1'b1;
        if (w_state_n == S_START)
            w_tx_n = 1'b0;
        else if (w_state_n == S_DATA)
            w_tx_n = w_byte[w_bit_n];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_hold  <= 16'd0;
            r_hi    <= 1'b0;
            r_addr  <= 8'd0;
            r_max   <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_tx    <= w_tx_n;
            if (r_state == S_IDLE && i_start) begin
                r_addr <= 8'd0;
                r_max  <= i_max_addr;
            end
            if (r_state == S_LATCH) begin
                r_hold <= i_rd_data;
                r_hi   <= 1'b1;
            end
            if (r_state == S_STOP && w_tick) begin
                if (r_hi)
                    r_hi <= 1'b0;
                else if (r_addr != r_max)
                    r_addr <= r_addr + 8'd1;
            end
        end
    end

    assign o_tx      = r_tx;
    assign o_rd_en   = (r_state == S_FETCH);
    assign o_rd_addr = r_addr;
    assign o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_instr_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_dump_tx
// Description : Self-checking bench for instr_dump_tx (CLK_DIV = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_dump_tx;

    localparam int CLK_DIV  = 16;
    localparam int FRAME    = 10 * CLK_DIV;
    localparam int WORD_CYC = 2 + 2 * FRAME;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  max_addr;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data = 16'd0;
    logic        tx;
    logic        busy;
    logic        done;

    logic [15:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int frame_cnt = 0;
    int stop_bad = 0;
    int max_seen = 0;
    logic [7:0] rx_q [$];
    logic [7:0] got [$];

    instr_dump_tx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_max_addr(max_addr),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_tx(tx), .o_busy(busy), .o_done(done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // UART receiver: samples every bit at its middle cycle.
    initial begin : uart_rx
        logic [7:0] b;
        b = 8'd0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && rst === 1'b0) begin
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (tx !== 1'b1) stop_bad++;
                rx_q.push_back(b);
                frame_cnt++;
            end
        end
    end

    typedef struct packed {
        logic       tx;
        logic       rd_en;
        logic [7:0] addr;
        logic       busy;
        logic       done;
    } exp_t;

    // Expected outputs k cycles after the start was accepted, for n words.
    function automatic exp_t model(input int k, input int n);
        exp_t e;
        int w, r, j, pos;
        logic [7:0] by;
        e = '{tx: 1'b1, rd_en: 1'b0, addr: 8'd0, busy: 1'b0, done: 1'b0};
        if (k >= 1 && k <= n * WORD_CYC) begin
            w = (k - 1) / WORD_CYC;
            r = (k - 1) % WORD_CYC;
            e.busy = 1'b1;
            if (r == 0) begin
                e.rd_en = 1'b1;
                e.addr  = 8'(w);
            end else if (r >= 2) begin
                j   = r - 2;
                by  = (j < FRAME) ? mem[w][15:8] : mem[w][7:0];
                pos = (j % FRAME) / CLK_DIV;
                if (pos == 0)
                    e.tx = 1'b0;
                else if (pos <= 8)
                    e.tx = by[pos-1];
            end
        end else if (k == n * WORD_CYC + 1) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic agg(input string name, input int errs, input int fk,
                       input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad cycles, first at cycle %0d actual=%0h required=%0h",
                     name, errs, fk, act, req);
        end
    endtask

    task automatic run_dump(input logic [7:0] m, input bit poke, input string tag);
        int n, f0, d0, s0;
        int e_tx, e_rd, e_bs, e_dn, e_by;
        int k_tx, k_rd, k_bs, k_dn, k_by;
        logic [31:0] a_tx, a_rd, a_bs, a_dn, a_by, r_tx, r_rd, r_bs, r_dn, r_by;
        exp_t e;
        logic [7:0] xb;
        n = int'(m) + 1;
        f0 = frame_cnt; d0 = done_cnt; s0 = stop_bad;
        e_tx = 0; e_rd = 0; e_bs = 0; e_dn = 0; e_by = 0;
        k_tx = 0; k_rd = 0; k_bs = 0; k_dn = 0; k_by = 0;
        a_tx = 0; a_rd = 0; a_bs = 0; a_dn = 0; a_by = 0;
        r_tx = 0; r_rd = 0; r_bs = 0; r_dn = 0; r_by = 0;
        max_seen = 0;
        rx_q.delete();
        @(negedge clk);
        max_addr = m;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n * WORD_CYC + 4; k++) begin
            e = model(k, n);
            if (tx !== e.tx) begin
                if (e_tx == 0) begin k_tx = k; a_tx = 32'(tx); r_tx = 32'(e.tx); end
                e_tx++;
            end
            if (rd_en !== e.rd_en || (e.rd_en && rd_addr !== e.addr)) begin
                if (e_rd == 0) begin
                    k_rd = k; a_rd = {23'd0, rd_en, rd_addr}; r_rd = {23'd0, e.rd_en, e.addr};
                end
                e_rd++;
            end
            if (busy !== e.busy) begin
                if (e_bs == 0) begin k_bs = k; a_bs = 32'(busy); r_bs = 32'(e.busy); end
                e_bs++;
            end
            if (done !== e.done) begin
                if (e_dn == 0) begin k_dn = k; a_dn = 32'(done); r_dn = 32'(e.done); end
                e_dn++;
            end
            if (rd_en === 1'b1 && int'(rd_addr) > max_seen) max_seen = int'(rd_addr);
            if (poke) begin
                start = (k == 30 || k == 330);
                if (k == 20)  max_addr = 8'd0;
                if (k == 400) max_addr = 8'd5;
            end
            @(negedge clk);
        end
        start = 1'b0;
        got = rx_q;
        for (int i = 0; i < got.size() && i < 2 * n; i++) begin
            xb = (i % 2 == 0) ? mem[i/2][15:8] : mem[i/2][7:0];
            if (got[i] !== xb) begin
                if (e_by == 0) begin k_by = i; a_by = 32'(got[i]); r_by = 32'(xb); end
                e_by++;
            end
        end
        agg({tag, " tx waveform"}, e_tx, k_tx, a_tx, r_tx);
        agg({tag, " rd_en/addr"},  e_rd, k_rd, a_rd, r_rd);
        agg({tag, " busy"},        e_bs, k_bs, a_bs, r_bs);
        agg({tag, " done timing"}, e_dn, k_dn, a_dn, r_dn);
        agg({tag, " rx bytes"},    e_by, k_by, a_by, r_by);
        chk({tag, " done count"},  32'(done_cnt - d0), 32'd1);
        chk({tag, " frame count"}, 32'(frame_cnt - f0), 32'(2 * n));
        chk({tag, " stop bits"},   32'(stop_bad - s0), 32'd0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] max;
        logic [15:0] w [3];
        bit         poke;
        int         frames;
        logic [7:0] b [6];
    } vec_t;

    vec_t vecs [3];

    initial begin
        int errs;
        logic [7:0] m;
        vecs[0].name = "single";  vecs[0].max = 8'd0; vecs[0].poke = 1'b0; vecs[0].frames = 2;
        vecs[0].w[0] = 16'hA55A; vecs[0].w[1] = 16'h0000; vecs[0].w[2] = 16'h0000;
        vecs[0].b[0] = 8'hA5; vecs[0].b[1] = 8'h5A; vecs[0].b[2] = 8'h00;
        vecs[0].b[3] = 8'h00; vecs[0].b[4] = 8'h00; vecs[0].b[5] = 8'h00;
        vecs[1].name = "multi";   vecs[1].max = 8'd2; vecs[1].poke = 1'b0; vecs[1].frames = 6;
        vecs[1].w[0] = 16'h1234; vecs[1].w[1] = 16'h5678; vecs[1].w[2] = 16'h9ABC;
        vecs[1].b[0] = 8'h12; vecs[1].b[1] = 8'h34; vecs[1].b[2] = 8'h56;
        vecs[1].b[3] = 8'h78; vecs[1].b[4] = 8'h9A; vecs[1].b[5] = 8'hBC;
        vecs[2].name = "ignored"; vecs[2].max = 8'd1; vecs[2].poke = 1'b1; vecs[2].frames = 4;
        vecs[2].w[0] = 16'h0FF1; vecs[2].w[1] = 16'hE00F; vecs[2].w[2] = 16'h0000;
        vecs[2].b[0] = 8'h0F; vecs[2].b[1] = 8'hF1; vecs[2].b[2] = 8'hE0;
        vecs[2].b[3] = 8'h0F; vecs[2].b[4] = 8'h00; vecs[2].b[5] = 8'h00;

        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        rst = 1'b1; start = 1'b0; max_addr = 8'd0;
        #2;
        chk("reset tx",      32'(tx),      32'd1);
        chk("reset busy",    32'(busy),    32'd0);
        chk("reset done",    32'(done),    32'd0);
        chk("reset rd_en",   32'(rd_en),   32'd0);
        chk("reset rd_addr", 32'(rd_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 3; i++) mem[i] = vecs[v].w[i];
            run_dump(vecs[v].max, vecs[v].poke, vecs[v].name);
            errs = 0;
            for (int i = 0; i < vecs[v].frames; i++)
                if (i >= got.size() || got[i] !== vecs[v].b[i]) errs++;
            agg({vecs[v].name, " table bytes"}, errs, 0, 32'(got.size()), 32'(vecs[v].frames));
        end

        // Reset in the middle of data bit 3 of the first frame.
        mem[0] = 16'hA55A;
        @(negedge clk);
        max_addr = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (74) @(negedge clk);
        chk("pre-reset tx bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("midreset tx",      32'(tx),      32'd1);
        chk("midreset busy",    32'(busy),    32'd0);
        chk("midreset rd_en",   32'(rd_en),   32'd0);
        chk("midreset done",    32'(done),    32'd0);
        chk("midreset rd_addr", 32'(rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 200; k++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) errs++;
            @(negedge clk);
        end
        agg("post-reset idle", errs, 0, 32'(errs), 32'd0);
        mem[0] = 16'hC33C; mem[1] = 16'h7E81;
        run_dump(8'd1, 1'b0, "after reset");

        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 4; i++) mem[i] = 16'($urandom);
            m = 8'($urandom_range(0, 1));
            run_dump(m, 1'($urandom_range(0, 1)), "random");
        end

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        run_dump(8'd255, 1'b0, "full range");
        chk("full range max addr", 32'(max_seen), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_dump_tx.md
INSTR_DUMP_TX -- requirements
Module: instr_dump_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate; CLK_DIV = CLK_FREQ/BAUD_RATE (integer divide), and CLK_DIV >= 2 is required.
REQ-003 SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_start  input  1  single-cycle request to begin a dump.
REQ-006 SHALL have port i_max_addr  input  8  last instruction address to dump, inclusive.
REQ-007 SHALL have port o_rd_en  output  1  instruction-memory read enable.
REQ-008 SHALL have port o_rd_addr  output  8  instruction-memory read address.
REQ-009 SHALL have port i_rd_data  input  16  read data, valid on the cycle after o_rd_en=1 (synchronous memory, 1-cycle latency).
REQ-010 SHALL have port o_tx  output  1  UART serial line, 8N1, idle high.
REQ-011 SHALL have port o_busy  output  1  dump in progress.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse at dump completion.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, LATCH, START, DATA, STOP, DONE.
REQ-014 SHALL, in IDLE with i_start=1, latch i_max_addr, clear the word address to 0, set o_busy=1, and enter FETCH on the next cycle; i_start outside IDLE SHALL be ignored.
REQ-015 SHALL, in FETCH, drive o_rd_en=1 and o_rd_addr=word address for exactly one cycle, then go to LATCH.
REQ-016 SHALL, in LATCH, capture i_rd_data into a 16-bit holding register, select the high byte, and go to START.
REQ-017 SHALL hold o_tx=0 for exactly CLK_DIV cycles in START, then go to DATA.
REQ-018 SHALL send 8 data bits LSB first in DATA, each for exactly CLK_DIV cycles, with a 3-bit bit index; after bit 7 it SHALL go to STOP.
REQ-019 SHALL hold o_tx=1 for exactly CLK_DIV cycles in STOP; after the high byte it SHALL select the low byte and go directly to START (no gap).
REQ-020 SHALL, after the low-byte STOP, go to DONE if word address equals the latched max address; otherwise it SHALL increment the word address and go to FETCH, giving a 2-cycle idle-high gap between words.
REQ-021 SHALL send the word high byte [15:8] first, then the low byte [7:0].
REQ-022 SHALL assert o_done=1 for one cycle in DONE, set o_busy=0 in that same cycle, and return to IDLE.
REQ-023 SHALL compare the word address before incrementing it, so a max address of 255 dumps 256 words with no wrap and no extra word.
REQ-024 SHALL ignore changes on i_max_addr after the start is accepted.
REQ-025 SHALL drive o_tx from a register, with o_tx=1 in IDLE, FETCH, LATCH and DONE.
REQ-026 SHALL use a baud counter of width ceil(log2(CLK_DIV)) that restarts at 0 on each state entry into START, DATA or STOP.

Reset
REQ-027 SHALL, while i_rst=1, immediately force o_tx=1, o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0, FSM=IDLE, and clear all counters and the holding register.
REQ-028 SHALL, on reset mid-frame, permit a truncated frame on the line; after i_rst deasserts, the next i_start SHALL begin a clean dump from address 0.

Verification (CLK_FREQ=16, BAUD_RATE=1, CLK_DIV=16)
REQ-029 SHALL check reset: assert i_rst -> o_tx=1, o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0 with no clock edge.
REQ-030 SHALL check a single word: mem[0]=16'hA55A, i_max_addr=0, i_start pulse -> o_rd_en at start+1 with addr 0, start bit at start+3, frames 0xA5 then 0x5A (LSB first, 320 bit-cycles), o_done one cycle after the last stop bit, exactly one o_done.
REQ-031 SHALL check a multi-word dump: mem[0..2]=16'h1234/16'h5678/16'h9ABC, i_max_addr=2 -> bytes 12 34 56 78 9A BC, three single-cycle o_rd_en on addresses 0, 1, 2, and a 2-cycle idle gap between words.
REQ-032 SHALL check ignored inputs: i_start pulses and i_max_addr=0→5 during a dump with i_max_addr=1 -> exactly 4 frames, one o_done.
REQ-033 SHALL check reset mid-operation: i_rst during DATA bit 3 -> o_tx=1 asynchronously and state IDLE; a subsequent i_start dumps from address 0 correctly.
REQ-034 SHALL check the full range: i_max_addr=255 -> 512 frames, o_rd_addr reaches 255 with no wrap to 0, and o_done pulses once.
